mem_ctrl: RTL and testbench

- Bus-side controller sitting directly upstream of the 256x32 main-memory RAM (8-bit address, 32-bit data, level-sensitive we/re).
- Accepts single read/write requests from the CPU datapath over a valid/ready handshake and holds them in internal MAR/MDR registers.
- Sequences the RAM strobes so that address and data are stable before and after every strobe, then returns a response.
- Makes the combinational-enable RAM safe to use from clocked CPU logic.

---
 rtl/mem_ctrl_pkg.sv | 17 +
 rtl/mem_ctrl_if.sv | 38 +++
 rtl/mem_wait_timer.sv | 27 ++
 rtl/mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_ctrl.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_ctrl_pkg.sv
// Shared types and defaults for the main-memory controller slice.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W    = 8;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MEM_DEPTH = 256;
  localparam int WAIT_W        = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    ACCESS = 3'd2,
    HOLD   = 3'd3,
    RESP   = 3'd4
  } state_t;

endpackage

// File: rtl/mem_ctrl_if.sv
// CPU request/response channel plus the RAM strobe bus of the memory controller.
interface mem_ctrl_if #(
  parameter int ADDR_W = mem_ctrl_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_ctrl_pkg::DEF_DATA_W
);
  // valid/ready: a transfer happens on a rising edge where valid && ready are both 1;
  // the valid side holds valid and its payload unchanged until that edge.
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic [ADDR_W-1:0] ram_address;
  logic [DATA_W-1:0] ram_data_in;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_data_out;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready, ram_data_out,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output ram_address, ram_data_in, ram_we, ram_re
  );

  modport ram (
    input  ram_address, ram_data_in, ram_we, ram_re,
    output ram_data_out
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Down-counter setting the ACCESS dwell; zero flags the final strobe cycle.
module mem_wait_timer
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WAIT_W-1:0] load_value,
  input  logic              dec_en,
  output logic              zero
);

  logic [WAIT_W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec_en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_ctrl.sv
// Sequences a combinational-enable RAM from a registered request/response handshake.
// Optional out-of-range rejection is compiled in with MEM_CTRL_BOUND_CHECK_EN.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_STATES = 1,
  parameter int MEM_DEPTH   = DEF_MEM_DEPTH
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_ctrl_if.slave bus,
  output state_t   dbg_state
);

  if (WAIT_STATES < 0 || WAIT_STATES > 15 || MEM_DEPTH < 1 || MEM_DEPTH > (1 << ADDR_W)) begin : g_bad_cfg
    $error("mem_ctrl: WAIT_STATES or MEM_DEPTH out of range");
  end

  state_t            state, next_state;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr, din;
  logic              wr;
  logic              wait_zero;
  logic              oor;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              ram_we_q, ram_we_d;
  logic              ram_re_q, ram_re_d;

`ifdef MEM_CTRL_BOUND_CHECK_EN
  logic rsp_err_q, rsp_err_d;
  assign oor = (32'(bus.req_addr) >= 32'(MEM_DEPTH));
`else
  assign oor = 1'b0;
`endif

  mem_wait_timer u_wait (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (state == SETUP),
    .load_value (WAIT_W'(WAIT_STATES)),
    .dec_en     (state == ACCESS),
    .zero       (wait_zero)
  );

  // Outputs are computed from next_state so they register alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      ram_we_q    <= 1'b0;
      ram_re_q    <= 1'b0;
`ifdef MEM_CTRL_BOUND_CHECK_EN
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      state       <= next_state;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      ram_we_q    <= ram_we_d;
      ram_re_q    <= ram_re_d;
`ifdef MEM_CTRL_BOUND_CHECK_EN
      rsp_err_q   <= rsp_err_d;
`endif
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (bus.req_valid) next_state = oor ? RESP : SETUP;
      SETUP:   next_state = ACCESS;
      ACCESS:  if (wait_zero) next_state = HOLD;
      HOLD:    next_state = RESP;
      RESP:    if (bus.rsp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    req_ready_d = (next_state == IDLE);
    rsp_valid_d = (next_state == RESP);
    ram_we_d    = (next_state == ACCESS) && wr;
    ram_re_d    = (next_state == ACCESS) && !wr;
    rsp_rdata_d = '0;
`ifdef MEM_CTRL_BOUND_CHECK_EN
    rsp_err_d   = 1'b0;
`endif
    if (state == RESP && next_state == RESP) begin
      rsp_rdata_d = rsp_rdata_q;
`ifdef MEM_CTRL_BOUND_CHECK_EN
      rsp_err_d   = rsp_err_q;
`endif
    end else if (state == HOLD) begin
      rsp_rdata_d = wr ? '0 : mdr;
    end
`ifdef MEM_CTRL_BOUND_CHECK_EN
    else if (state == IDLE && next_state == RESP) begin
      rsp_err_d = 1'b1;
    end
`endif
  end

  // MAR/ram_data_in load only on the IDLE->SETUP edge so the RAM never sees them move mid-access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mar <= '0;
      din <= '0;
      mdr <= '0;
      wr  <= 1'b0;
    end else if (state == IDLE && bus.req_valid && !oor) begin
      mar <= bus.req_addr;
      din <= bus.req_wdata;
      mdr <= bus.req_wdata;
      wr  <= bus.req_we;
    end else if (state == ACCESS && wait_zero && !wr) begin
      mdr <= bus.ram_data_out;
    end
  end

  assign bus.req_ready   = req_ready_q;
  assign bus.rsp_valid   = rsp_valid_q;
  assign bus.rsp_rdata   = rsp_rdata_q;
  assign bus.ram_address = mar;
  assign bus.ram_data_in = din;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_re      = ram_re_q;
`ifdef MEM_CTRL_BOUND_CHECK_EN
  assign bus.rsp_err     = rsp_err_q;
`else
  assign bus.rsp_err     = 1'b0;
`endif
  assign dbg_state       = state;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: three instances (WAIT_STATES 1, 0, 3) each with a RAM model.
`timescale 1ns/1ps
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  localparam int N = 3;
`ifdef MEM_CTRL_BOUND_CHECK_EN
  localparam bit BC    = 1'b1;
  localparam int DEPTH = 128;
`else
  localparam bit BC    = 1'b0;
  localparam int DEPTH = 256;
`endif

  typedef struct {
    int          inst;
    bit          we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          stall;
    logic [31:0] rdata;
    bit          err;
    int          lat;
    int          strobe;
  } vec_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0] req_valid_a, req_we_a, rsp_ready_a;
  logic [N-1:0] req_ready_a, rsp_valid_a, rsp_err_a, ram_we_a, ram_re_a;
  logic [7:0]   req_addr_a [N];
  logic [31:0]  req_wdata_a [N];
  logic [31:0]  rsp_rdata_a [N];
  logic [31:0]  ram_data_in_a [N];
  logic [7:0]   ram_address_a [N];
  state_t       dbg_state_a [N];
  logic [31:0]  ram_mem [N][256];
  logic [31:0]  ref_mem [N][256];
  logic [31:0]  exp_q [$];
  int total = 0;
  int bad = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int WS = (g == 0) ? 1 : (g == 1) ? 0 : 3;
    mem_ctrl_if bus ();
    assign bus.req_valid     = req_valid_a[g];
    assign bus.req_we        = req_we_a[g];
    assign bus.req_addr      = req_addr_a[g];
    assign bus.req_wdata     = req_wdata_a[g];
    assign bus.rsp_ready     = rsp_ready_a[g];
    assign bus.ram_data_out  = bus.ram_re ? ram_mem[g][bus.ram_address] : 32'h0;
    assign req_ready_a[g]    = bus.req_ready;
    assign rsp_valid_a[g]    = bus.rsp_valid;
    assign rsp_rdata_a[g]    = bus.rsp_rdata;
    assign rsp_err_a[g]      = bus.rsp_err;
    assign ram_we_a[g]       = bus.ram_we;
    assign ram_re_a[g]       = bus.ram_re;
    assign ram_address_a[g]  = bus.ram_address;
    assign ram_data_in_a[g]  = bus.ram_data_in;

    mem_ctrl #(
      .ADDR_W      (8),
      .DATA_W      (32),
      .WAIT_STATES (WS),
      .MEM_DEPTH   (DEPTH)
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .dbg_state (dbg_state_a[g])
    );
  end

  // RAM model: level-sensitive write, committed at the clock while we is high
  always @(posedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (ram_we_a[k]) ram_mem[k][ram_address_a[k]] <= ram_data_in_a[k];
    end
  end

  function automatic int ws_of(int i);
    return (i == 0) ? 1 : (i == 1) ? 0 : 3;
  endfunction

  function automatic logic [31:0] init_word(int k, int a);
    return 32'hC0DE_0000 | 32'(k << 8) | 32'(a);
  endfunction

  // reference model: expected outcome of one request from the memory image
  function automatic vec_t make_vec(int i, bit we, logic [7:0] a, logic [31:0] d, int stall);
    vec_t v;
    bit inr;
    inr      = !BC || (int'(a) < DEPTH);
    v.inst   = i;
    v.we     = we;
    v.addr   = a;
    v.wdata  = d;
    v.stall  = stall;
    v.err    = !inr;
    v.lat    = inr ? ws_of(i) + 3 : 0;
    v.strobe = inr ? ws_of(i) + 1 : 0;
    v.rdata  = (inr && !we) ? ref_mem[i][a] : 32'h0;
    return v;
  endfunction

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // driver: present request at a negedge, return at the negedge after the accepting edge
  task automatic issue(vec_t v, output int waits);
    int i;
    i = v.inst;
    req_valid_a[i] = 1'b1;
    req_we_a[i]    = v.we;
    req_addr_a[i]  = v.addr;
    req_wdata_a[i] = v.wdata;
    waits = 0;
    while (!req_ready_a[i] && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    check("accept_wait", 64'(waits < 50), 64'(1));
    @(posedge clk);
    @(negedge clk);
    req_valid_a[i] = 1'b0;
    check("accept_drops_ready", 64'(req_ready_a[i]), 64'(0));
  endtask

  task automatic collect(vec_t v);
    int i, lat, we_n, re_n;
    bit both, moved, held;
    logic [31:0] rd;
    logic er;
    i = v.inst; lat = 0; we_n = 0; re_n = 0; both = 0; moved = 0; held = 1;
    while (!rsp_valid_a[i] && lat < 40) begin
      if (ram_we_a[i] && ram_re_a[i]) both = 1;
      if (ram_we_a[i]) we_n++;
      if (ram_re_a[i]) re_n++;
      if (ram_address_a[i] !== v.addr || ram_data_in_a[i] !== v.wdata) moved = 1;
      @(negedge clk);
      lat++;
    end
    check("latency", 64'(lat), 64'(v.lat));
    check("we_cycles", 64'(we_n), 64'(v.we ? v.strobe : 0));
    check("re_cycles", 64'(re_n), 64'(v.we ? 0 : v.strobe));
    check("strobe_overlap", 64'(both), 64'(0));
    if (!v.err) check("addr_data_stable", 64'(moved), 64'(0));
    rd = rsp_rdata_a[i];
    er = rsp_err_a[i];
    if (exp_q.size() == 0) check("scoreboard_empty", 64'(1), 64'(0));
    else check("rsp_rdata", 64'(rd), 64'(exp_q.pop_front()));
    check("rsp_err", 64'(er), 64'(v.err));
    for (int s = 0; s < v.stall; s++) begin
      @(negedge clk);
      if (!rsp_valid_a[i] || rsp_rdata_a[i] !== rd || rsp_err_a[i] !== er || req_ready_a[i]) held = 0;
    end
    if (v.stall > 0) check("stall_hold", 64'(held), 64'(1));
    rsp_ready_a[i] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready_a[i] = 1'b0;
    check("rsp_released", 64'(rsp_valid_a[i]), 64'(0));
  endtask

  task automatic run_op(vec_t v);
    int w;
    exp_q.push_back(v.rdata);
    issue(v, w);
    collect(v);
    if (v.we && !v.err) ref_mem[v.inst][v.addr] = v.wdata;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tab [11];
    vec_t v, p;
    int   w;
    bit   seen;
    int   ri;
    bit   rwe;
    logic [7:0] ra;

    for (int k = 0; k < N; k++) begin
      req_valid_a[k] = 1'b0; req_we_a[k] = 1'b0; rsp_ready_a[k] = 1'b0;
      req_addr_a[k] = 8'h0;  req_wdata_a[k] = 32'h0;
      for (int a = 0; a < 256; a++) begin
        ram_mem[k][a] = init_word(k, a);
        ref_mem[k][a] = init_word(k, a);
      end
    end

    // reset held with a request pending
    v = make_vec(0, 1'b1, 8'h05, 32'h1111_1111, 0);
    req_valid_a[0] = 1'b1; req_we_a[0] = 1'b1; req_addr_a[0] = v.addr; req_wdata_a[0] = v.wdata;
    repeat (3) @(negedge clk);
    check("reset_ctrl", 64'({req_ready_a[0], rsp_valid_a[0], rsp_err_a[0], ram_we_a[0], ram_re_a[0]}), 64'(5'b10000));
    check("reset_bus", 64'({ram_address_a[0], ram_data_in_a[0]}), 64'(0));
    check("reset_rdata", 64'(rsp_rdata_a[0]), 64'(0));
    check("reset_state", 64'(dbg_state_a[0]), 64'(IDLE));
    rst_n = 1'b1;
    exp_q.push_back(v.rdata);
    issue(v, w);
    check("accept_first_edge", 64'(w), 64'(0));
    collect(v);
    ref_mem[0][8'h05] = v.wdata;

    // directed vectors
    tab[0]  = '{0, 1'b1, 8'h10, 32'hDEAD_BEEF, 0, 32'h0, 1'b0, 4, 2};
    tab[1]  = '{0, 1'b0, 8'h10, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, 4, 2};
    tab[2]  = '{0, 1'b1, 8'hFF, 32'h1234_5678, 0, 32'h0, BC, BC ? 0 : 4, BC ? 0 : 2};
    tab[3]  = '{0, 1'b0, 8'hFF, 32'h0, 2, BC ? 32'h0 : 32'h1234_5678, BC, BC ? 0 : 4, BC ? 0 : 2};
    tab[4]  = '{1, 1'b1, 8'h20, 32'hA5A5_A5A5, 0, 32'h0, 1'b0, 3, 1};
    tab[5]  = '{1, 1'b0, 8'h20, 32'h0, 1, 32'hA5A5_A5A5, 1'b0, 3, 1};
    tab[6]  = '{2, 1'b1, 8'h30, 32'h0F0F_0F0F, 0, 32'h0, 1'b0, 6, 4};
    tab[7]  = '{2, 1'b0, 8'h30, 32'h0, 0, 32'h0F0F_0F0F, 1'b0, 6, 4};
    tab[8]  = '{1, 1'b0, 8'h00, 32'h5555_0000, 0, 32'hC0DE_0100, 1'b0, 3, 1};
    tab[9]  = '{2, 1'b0, 8'h7F, 32'h0, 0, 32'hC0DE_027F, 1'b0, 6, 4};
    tab[10] = '{0, 1'b0, 8'h80, 32'h0, 0, BC ? 32'h0 : 32'hC0DE_0080, BC, BC ? 0 : 4, BC ? 0 : 2};
    for (int t = 0; t < 11; t++) run_op(tab[t]);

    // back-pressure with a second request waiting
    v = make_vec(0, 1'b0, 8'hFF, 32'h0, 5);
    exp_q.push_back(v.rdata);
    issue(v, w);
    p = make_vec(0, 1'b1, 8'h40, 32'h4040_4040, 0);
    req_valid_a[0] = 1'b1; req_we_a[0] = 1'b1; req_addr_a[0] = p.addr; req_wdata_a[0] = p.wdata;
    collect(v);
    check("pending_waits_for_idle", 64'(req_ready_a[0]), 64'(1));
    exp_q.push_back(p.rdata);
    @(posedge clk);
    @(negedge clk);
    req_valid_a[0] = 1'b0;
    check("pending_accepted", 64'(req_ready_a[0]), 64'(0));
    collect(p);
    ref_mem[0][8'h40] = p.wdata;

    // reset in the middle of a read access
    v = make_vec(0, 1'b0, 8'h10, 32'h0, 0);
    issue(v, w);
    @(negedge clk);
    check("mid_access_re", 64'(ram_re_a[0]), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    check("async_clear_ctrl", 64'({ram_re_a[0], ram_we_a[0], rsp_valid_a[0], req_ready_a[0]}), 64'(4'b0001));
    check("async_clear_addr", 64'(ram_address_a[0]), 64'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid_a[0]) seen = 1;
    end
    check("no_rsp_after_reset", 64'(seen), 64'(0));
    run_op(make_vec(0, 1'b0, 8'h10, 32'h0, 1));

    // randomized traffic against the memory image
    for (int n = 0; n < 45; n++) begin
      ri  = $urandom_range(0, N - 1);
      rwe = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) ra = 8'($urandom_range(0, 255));
      else ra = 8'(8'h78 + $urandom_range(0, 15));
      run_op(make_vec(ri, rwe, ra, $urandom, $urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
